// File: rtl/vram_stroke_writer_pkg.sv
// Shared types for the VRAM stroke writer: touch sample, colour, FSM states.
// Coordinates are 10 bits wide, enough for both 0..239 and 0..319.
package vram_stroke_writer_pkg;

    localparam int COORD_W = 10;

    typedef logic [15:0] ILI9341_color_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } touch_t;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_SETUP,
        S_LINE
    } state_t;

endpackage

// File: rtl/vram_stroke_writer_line_stepper.sv
// Bresenham line walker: load latches start/end and deltas, step advances
// one pixel and exposes the stepped point combinationally.
module vram_stroke_writer_line_stepper
    import vram_stroke_writer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y,
    output logic               done
);

    logic [COORD_W-1:0] x_q, y_q, ex_q, ey_q;
    logic signed [10:0] dx_q, dy_q, err_q;
    logic               sx_neg_q, sy_neg_q;

    logic signed [10:0] ddx, ddy, ld_dx, ld_dy, err_n;
    logic signed [11:0] e2, dx12, dy12;
    logic               c_x, c_y;

    // Deltas for a new segment and the single Bresenham step from the current point
    always_comb begin
        ddx   = $signed({1'b0, x1}) - $signed({1'b0, x0});
        ddy   = $signed({1'b0, y1}) - $signed({1'b0, y0});
        ld_dx = ddx[10] ? -ddx : ddx;
        ld_dy = ddy[10] ? ddy : -ddy;
        e2    = {err_q, 1'b0};
        dx12  = {dx_q[10], dx_q};
        dy12  = {dy_q[10], dy_q};
        c_x   = (e2 >= dy12);
        c_y   = (e2 <= dx12);
        nxt_x = x_q;
        nxt_y = y_q;
        if (c_x) nxt_x = sx_neg_q ? x_q - 10'd1 : x_q + 10'd1;
        if (c_y) nxt_y = sy_neg_q ? y_q - 10'd1 : y_q + 10'd1;
        err_n = err_q + (c_x ? dy_q : 11'sd0) + (c_y ? dx_q : 11'sd0);
        done  = (x_q == ex_q) && (y_q == ey_q);
    end

    // Segment registers: reload on load, advance on step
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else if (load) begin
            x_q      <= x0;
            y_q      <= y0;
            ex_q     <= x1;
            ey_q     <= y1;
            dx_q     <= ld_dx;
            dy_q     <= ld_dy;
            err_q    <= ld_dx + ld_dy;
            sx_neg_q <= ddx[10];
            sy_neg_q <= ddy[10];
        end else if (step) begin
            x_q   <= nxt_x;
            y_q   <= nxt_y;
            err_q <= err_n;
        end
    end

endmodule

// File: rtl/vram_stroke_writer.sv
// Owns the VRAM write port: clears the frame, plots taps and joins successive
// touch samples into Bresenham strokes, one registered write per clock.
module vram_stroke_writer
    import vram_stroke_writer_pkg::*;
#(
    parameter  int DISPLAY_WIDTH  = 240,
    parameter  int DISPLAY_HEIGHT = 320,
    localparam int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int ADDR_W         = $clog2(VRAM_L)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  touch_t            touch,
    input  ILI9341_color_t    color,
    input  ILI9341_color_t    clear_color,
    output logic              vram_wr_ena,
    output logic [ADDR_W-1:0] vram_wr_addr,
    output ILI9341_color_t    vram_wr_data,
    output logic              busy
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(DISPLAY_WIDTH);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(DISPLAY_HEIGHT);
    localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(VRAM_L - 1);

    function automatic logic [ADDR_W-1:0] xy_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return ADDR_W'(y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(x);
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               have_prev_q, have_prev_d;
    logic [COORD_W-1:0] px_q, py_q, px_d, py_d;
    logic [COORD_W-1:0] ex_q, ey_q, ex_d, ey_d;
    logic               ena_d;
    logic [ADDR_W-1:0]  addr_d;
    ILI9341_color_t     data_d;
    logic               load, step, done;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               in_range;

    vram_stroke_writer_line_stepper u_stepper (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .x0    (px_q),
        .y0    (py_q),
        .x1    (touch.x),
        .y1    (touch.y),
        .nxt_x (nxt_x),
        .nxt_y (nxt_y),
        .done  (done)
    );

    // Next state, pen tracking and the write to be registered this cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        have_prev_d = have_prev_q;
        px_d        = px_q;
        py_d        = py_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        ena_d       = 1'b0;
        addr_d      = vram_wr_addr;
        data_d      = vram_wr_data;
        load        = 1'b0;
        step        = 1'b0;
        in_range    = (touch.x < X_LIM) && (touch.y < Y_LIM);
        if (clear) begin
            state_d     = S_CLEAR;
            cnt_d       = LAST;
            have_prev_d = 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    ena_d       = 1'b1;
                    addr_d      = cnt_q;
                    data_d      = clear_color;
                    have_prev_d = 1'b0;
                    if (cnt_q == '0) state_d = S_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_IDLE: begin
                    if (!touch.valid) begin
                        have_prev_d = 1'b0;
                    end else if (!in_range) begin
                        have_prev_d = have_prev_q;
                    end else if (!have_prev_q) begin
                        ena_d       = 1'b1;
                        addr_d      = xy_addr(touch.x, touch.y);
                        data_d      = color;
                        px_d        = touch.x;
                        py_d        = touch.y;
                        have_prev_d = 1'b1;
                    end else if (touch.x != px_q || touch.y != py_q) begin
                        ex_d    = touch.x;
                        ey_d    = touch.y;
                        load    = 1'b1;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    step    = 1'b1;
                    ena_d   = 1'b1;
                    addr_d  = xy_addr(nxt_x, nxt_y);
                    data_d  = color;
                    state_d = S_LINE;
                end
                S_LINE: begin
                    if (done) begin
                        px_d    = ex_q;
                        py_d    = ey_q;
                        state_d = S_IDLE;
                    end else begin
                        step   = 1'b1;
                        ena_d  = 1'b1;
                        addr_d = xy_addr(nxt_x, nxt_y);
                        data_d = color;
                    end
                end
                default: state_d = S_CLEAR;
            endcase
        end
    end

    // State and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= LAST;
            have_prev_q  <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            ex_q         <= '0;
            ey_q         <= '0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            have_prev_q  <= have_prev_d;
            px_q         <= px_d;
            py_q         <= py_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            vram_wr_ena  <= ena_d;
            vram_wr_addr <= addr_d;
            vram_wr_data <= data_d;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_vram_stroke_writer.sv
// Directed bench for vram_stroke_writer: expected writes go into a scoreboard
// with their cycle stamp; a negedge monitor pops and compares.
module tb_vram_stroke_writer;
    import vram_stroke_writer_pkg::*;

    localparam int W  = 240;
    localparam int H  = 40;
    localparam int L  = W * H;
    localparam int AW = $clog2(L);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    touch_t         touch = '0;
    ILI9341_color_t color = 16'hF800;
    ILI9341_color_t clear_color = 16'h001F;
    logic           vram_wr_ena;
    logic [AW-1:0]  vram_wr_addr;
    ILI9341_color_t vram_wr_data;
    logic           busy;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    vram_stroke_writer #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .touch        (touch),
        .color        (color),
        .clear_color  (clear_color),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (vram_wr_ena === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d",
                         vram_wr_addr, vram_wr_data, cyc);
            end else begin
                e = sb.pop_front();
                if (int'(vram_wr_addr) != e.addr ||
                    int'(vram_wr_data) != e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d need addr=%0d data=%h cyc=%0d",
                             vram_wr_addr, vram_wr_data, cyc,
                             e.addr, e.data[15:0], e.cyc);
                end
            end
        end
    end

    task automatic push(input int a, input int d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic push_clear(input int first);
        for (int i = 0; i < L; i++) push(L - 1 - i, int'(clear_color), first + i);
    endtask

    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_touch(input logic v, input int x, input int y);
        touch.valid = v;
        touch.x     = 10'(x);
        touch.y     = 10'(y);
    endtask

    task automatic chk_busy(input string name, input logic want);
        checks++;
        if (busy !== want) begin
            errors++;
            $display("FAIL %s busy=%b need %b", name, busy, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int busy_low;

        // Reset: full clear from the top address down
        step_to(1);
        rst = 1'b0;
        chk_busy("busy_after_reset", 1'b1);
        push_clear(2);
        busy_low = 0;
        while (cyc < L) begin
            step_to(cyc + 1);
            if (busy !== 1'b1) busy_low++;
        end
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL busy_during_clear low_cycles=%0d need 0", busy_low);
        end
        step_to(L + 1);
        chk_busy("busy_after_clear", 1'b0);
        step_to(cyc + 3);

        // Tap from pen-up
        set_touch(1'b1, 10, 20);
        s = cyc + 1;
        push(4810, int'(color), s);
        step_to(s + 1);

        // Horizontal drag
        set_touch(1'b1, 13, 20);
        s = cyc + 1;
        push(4811, int'(color), s + 1);
        push(4812, int'(color), s + 2);
        push(4813, int'(color), s + 3);
        step_to(s + 3);
        chk_busy("busy_line_last", 1'b1);
        step_to(s + 4);
        chk_busy("busy_line_done", 1'b0);
        step_to(s + 6);

        // Pen-up, tap, diagonal
        color = 16'h07E0;
        set_touch(1'b0, 0, 0);
        step_to(cyc + 1);
        set_touch(1'b1, 5, 5);
        s = cyc + 1;
        push(1205, int'(color), s);
        step_to(s);
        set_touch(1'b1, 2, 8);
        s = cyc + 1;
        push(1444, int'(color), s + 1);
        push(1683, int'(color), s + 2);
        push(1922, int'(color), s + 3);
        step_to(s + 4);

        // Pen-up, tap at origin, steep line
        set_touch(1'b0, 0, 0);
        step_to(cyc + 1);
        set_touch(1'b1, 0, 0);
        s = cyc + 1;
        push(0, int'(color), s);
        step_to(s);
        set_touch(1'b1, 1, 3);
        s = cyc + 1;
        push(240, int'(color), s + 1);
        push(481, int'(color), s + 2);
        push(721, int'(color), s + 3);
        step_to(s + 4);

        // Out-of-range samples keep the pen down
        set_touch(1'b1, W, 3);
        step_to(cyc + 1);
        set_touch(1'b1, 1, H);
        step_to(cyc + 1);
        set_touch(1'b1, 1, 320);
        step_to(cyc + 1);
        chk_busy("busy_out_of_range", 1'b0);
        set_touch(1'b1, 3, 3);
        s = cyc + 1;
        push(722, int'(color), s + 1);
        push(723, int'(color), s + 2);
        step_to(s + 3);

        // Ten-pixel line aborted by clear on its second pixel
        set_touch(1'b1, 13, 3);
        s = cyc + 1;
        push(724, int'(color), s + 1);
        step_to(s + 1);
        clear = 1'b1;
        push_clear(s + 3);
        step_to(s + 2);
        clear = 1'b0;
        chk_busy("busy_after_clear_req", 1'b1);
        step_to(s + L + 2);
        chk_busy("busy_after_clear2", 1'b0);
        push(733, int'(color), s + L + 3);
        step_to(s + L + 4);
        set_touch(1'b0, 0, 0);
        step_to(cyc + 4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes left=%0d need 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_stroke_writer.md
Name: vram_stroke_writer

Overview:
Sits between the FT6206 touch controller output (touch_t) and the VRAM block_ram write port, replacing per-sample pixel plotting. It clears VRAM on reset or request. It then turns successive valid touch samples into continuous strokes by rasterising a Bresenham line from the previous point to the new one, one VRAM write per clock. The display controller reads VRAM independently; this block owns the write port exclusively.

Parameters:
DISPLAY_WIDTH, 240, pixels per row; x range 0..239
DISPLAY_HEIGHT, 320, rows; y range 0..319
VRAM_L (localparam), DISPLAY_WIDTH*DISPLAY_HEIGHT, VRAM depth (76800)
ADDR_W (localparam), $clog2(VRAM_L), VRAM address width (17)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  single-cycle request to clear VRAM
touch  in  touch_t  live touch sample {valid, x, y}, level-valid
color  in  ILI9341_color_t  stroke colour, sampled when each pixel is emitted
clear_color  in  ILI9341_color_t  fill colour for clear
vram_wr_ena  out  1  VRAM write strobe
vram_wr_addr  out  ADDR_W  VRAM write address = y*DISPLAY_WIDTH + x
vram_wr_data  out  ILI9341_color_t  VRAM write data
busy  out  1  high in any state other than S_IDLE

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. Reset values: vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0, have_prev=0. The state goes to S_CLEAR, so busy=1 from the cycle after reset.
- States: S_CLEAR, S_IDLE, S_SETUP, S_LINE.
- S_CLEAR: counter starts at VRAM_L-1.
  - Each cycle it emits a write at counter with clear_color, then decrements.
  - After the write at address 0 (exactly VRAM_L writes), go to S_IDLE.
  - have_prev is forced to 0.
- S_IDLE, with touch sampled each cycle:
  - touch.valid=0: set have_prev=0; no write.
  - Valid but x>=DISPLAY_WIDTH or y>=DISPLAY_HEIGHT: discard; have_prev unchanged; no write.
  - Valid and have_prev=0: write a single pixel at (x,y) on the next cycle; set prev=(x,y) and have_prev=1; stay in S_IDLE.
  - Valid, have_prev=1, (x,y)==prev: no write.
  - Valid, have_prev=1, (x,y)!=prev: latch end=(x,y) and go to S_SETUP.
- S_SETUP (one cycle), signed 10-bit arithmetic:
  - dx=|x1-x0|; dy=-|y1-y0|; sx,sy=+/-1; err=dx+dy (11-bit signed).
  - Go to S_LINE.
- S_LINE: one pixel per cycle.
  - Step: e2=2*err. If e2>=dy then err+=dy, x+=sx. If e2<=dx then err+=dx, y+=sy.
  - Emit the stepped point (registered write).
  - When the emitted point == end: set prev=end, go to S_IDLE.
  - The start point is not re-emitted. Pixel count is max(dx,|dy|).
- Latency:
  - Single tap: sampled at cycle N, write visible at N+1.
  - Line: sample at N, S_SETUP at N+1, first write at N+2; last write at N+1+max(dx,|dy|); S_IDLE the following cycle.
- Touch samples arriving while not in S_IDLE are ignored (not queued).
- Address multiply: y*240+x, computed in the registered output stage. Must not overflow ADDR_W.
- Priority each cycle is rst > clear > state logic.
  - clear in any state, including S_CLEAR, restarts the clear at VRAM_L-1 and aborts any line in progress.
  - rst mid-line or mid-clear behaves identically to a power-on reset.
- vram_wr_ena is 0 in S_IDLE except for single-tap writes, and 0 in S_SETUP.

Decomposition:
- The ft6206 defines already provide touch_t. The ili9341 defines already provide ILI9341_color_t and the colour constants. Add nothing new to them.
- Put a vram_stroke_pkg-free localparam for DISPLAY_WIDTH/HEIGHT in the module.
- One natural sub-module, line_stepper. It holds the Bresenham registers (x, y, err, dx, dy, sx, sy) and has load/step/done ports. The parent FSM handles clearing, pen-state and VRAM address formation.

Test Plan:
1. rst high 1 cycle -> 76800 consecutive writes of clear_color, addresses 76799 down to 0, busy=1 throughout; busy=0 the next cycle; no writes while touch.valid=0.
2. After clear, touch valid at (10,20) from pen-up -> exactly one write, addr 4810, data=color, one cycle after sampling.
3. Hold valid, move (10,20)->(13,20) -> first write 2 cycles after sample; writes addr 4811, 4812, 4813 on consecutive cycles; no repeat of 4810.
4. Diagonal (5,5)->(2,8) -> writes 1444, 1683, 1922. Steep (0,0)->(1,3) -> writes 240, 481, 721.
5. Touch at x=240 or y=320 -> no write and have_prev kept. Pen-up then tap at (0,0) -> single write addr 0, no line drawn.
6. clear pulsed during the 2nd pixel of a 10-pixel line -> next write is addr 76799 with clear_color; no further line pixels; after the clear completes, the next touch is drawn as a single tap.
